demux_route_ctrl: RTL and testbench



---
 rtl/demux_route_ctrl.sv | 136 +++++++++++++
 tb/tb_demux_route_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_route_ctrl.sv
// 1-to-4 demux sequencing controller: addressed or burst round-robin routing through a one-entry hold register.
// Define DEMUX_ROUTE_STATS_EN to add per-channel saturating transfer counters (stat_clr, stat_cnt0..3).
module demux_route_ctrl #(
    parameter int DW        = 8,
    parameter int BURST_LEN = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] in_data,
    input  logic [1:0]    in_sel,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          mode,
    input  logic [3:0]    ch_en,
    output logic [DW-1:0] out_data,
    output logic [3:0]    out_valid,
    input  logic [3:0]    out_ready,
    output logic [1:0]    cur_ch,
    output logic          err_drop
`ifdef DEMUX_ROUTE_STATS_EN
    ,
    input  logic          stat_clr,
    output logic [15:0]   stat_cnt0,
    output logic [15:0]   stat_cnt1,
    output logic [15:0]   stat_cnt2,
    output logic [15:0]   stat_cnt3
`endif
);

    localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    typedef enum logic {IDLE, HOLD} state_t;

    state_t        state;
    logic [1:0]    rr_ptr;
    logic [CW-1:0] burst_cnt;

    logic          rr_stall;
    logic          rr_realign;
    logic          drain;
    logic          accept;
    logic          drop;
    logic          routed;
    logic [1:0]    dest_in;
    logic [1:0]    rr_next;
    logic [1:0]    rr_ptr_nxt;
    logic [CW-1:0] burst_nxt;

    // Closest enabled channel after p, wrapping; returns p itself when nothing else is enabled.
    function automatic logic [1:0] next_en(input logic [1:0] p, input logic [3:0] en);
        logic [1:0] r;
        r = p;
        for (int i = 3; i >= 1; i--) begin
            if (en[p + 2'(i)]) r = p + 2'(i);
        end
        return r;
    endfunction

    always_comb begin
        rr_next    = next_en(rr_ptr, ch_en);
        rr_stall   = mode && (ch_en == 4'b0000);
        rr_realign = mode && (ch_en != 4'b0000) && !ch_en[rr_ptr];
        drain      = (state == HOLD) && out_ready[cur_ch];
        in_ready   = !rr_stall && !rr_realign && ((state == IDLE) || out_ready[cur_ch]);
        accept     = in_valid && in_ready;
        dest_in    = mode ? rr_ptr : in_sel;
        drop       = accept && !mode && !ch_en[in_sel];
        routed     = accept && !drop;

        rr_ptr_nxt = rr_ptr;
        burst_nxt  = burst_cnt;
        if (!mode) begin
            burst_nxt = '0;
        end else if (rr_realign) begin
            rr_ptr_nxt = rr_next;
            burst_nxt  = '0;
        end else if (routed) begin
            if (burst_cnt == CW'(BURST_LEN - 1)) begin
                burst_nxt  = '0;
                rr_ptr_nxt = rr_next;
            end else begin
                burst_nxt = burst_cnt + CW'(1);
            end
        end
    end

    // cur_ch doubles as the latched destination while HOLD and tracks the pointer while IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 4'b0000;
            out_data  <= '0;
            cur_ch    <= 2'd0;
            rr_ptr    <= 2'd0;
            burst_cnt <= '0;
            err_drop  <= 1'b0;
        end else begin
            rr_ptr    <= rr_ptr_nxt;
            burst_cnt <= burst_nxt;
            err_drop  <= drop;
            if (routed) begin
                state     <= HOLD;
                out_data  <= in_data;
                out_valid <= 4'b0001 << dest_in;
                cur_ch    <= dest_in;
            end else if (drain) begin
                state     <= IDLE;
                out_valid <= 4'b0000;
                cur_ch    <= rr_ptr_nxt;
            end else if (state == IDLE) begin
                cur_ch    <= rr_ptr_nxt;
            end
        end
    end

`ifdef DEMUX_ROUTE_STATS_EN
    logic [15:0] stat_q [4];

    // Clear wins over a same-cycle increment; counts stick at all-ones.
    always_ff @(posedge clk) begin
        for (int n = 0; n < 4; n++) begin
            if (rst || stat_clr) begin
                stat_q[n] <= 16'h0000;
            end else if (out_valid[n] && out_ready[n] && (stat_q[n] != 16'hFFFF)) begin
                stat_q[n] <= stat_q[n] + 16'd1;
            end
        end
    end

    assign stat_cnt0 = stat_q[0];
    assign stat_cnt1 = stat_q[1];
    assign stat_cnt2 = stat_q[2];
    assign stat_cnt3 = stat_q[3];
`endif

endmodule

// File: tb/tb_demux_route_ctrl.sv
// Directed bench for demux_route_ctrl: queue scoreboard of {channel, data} checked on every output transfer.
module tb_demux_route_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic [1:0] in_sel;
    logic       in_valid;
    logic       in_ready;
    logic       mode;
    logic [3:0] ch_en;
    logic [7:0] out_data;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic [1:0] cur_ch;
    logic       err_drop;
`ifdef DEMUX_ROUTE_STATS_EN
    logic        stat_clr;
    logic [15:0] stat_cnt0, stat_cnt1, stat_cnt2, stat_cnt3;
`endif

    int         n_checks = 0;
    int         n_fails  = 0;
    logic [9:0] sb_q [$];
    logic [9:0] sb_head;

    always #5 clk = ~clk;

    demux_route_ctrl #(.DW(8), .BURST_LEN(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .ch_en     (ch_en),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cur_ch    (cur_ch),
        .err_drop  (err_drop)
`ifdef DEMUX_ROUTE_STATS_EN
        ,
        .stat_clr  (stat_clr),
        .stat_cnt0 (stat_cnt0),
        .stat_cnt1 (stat_cnt1),
        .stat_cnt2 (stat_cnt2),
        .stat_cnt3 (stat_cnt3)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic [1:0] s);
        in_valid = v;
        in_data  = d;
        in_sel   = s;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat for a cycle, check the expected acceptance, and queue it if it should reach a sink.
    task automatic beat(input logic [7:0] d, input logic [1:0] s, input logic exp_rdy,
                        input logic do_push, input logic [1:0] exp_ch);
        applyStimulus(1'b1, d, s);
        @(negedge clk);
        checkOutput($sformatf("in_ready_beat_%0h", d), 32'(in_ready), 32'(exp_rdy));
        if (do_push) sb_q.push_back({exp_ch, d});
        tick();
    endtask

    // Every completed transfer must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("out_valid_onehot", 32'($onehot0(out_valid)), 32'd1);
            for (int n = 0; n < 4; n++) begin
                if (out_valid[n] && out_ready[n]) begin
                    checkOutput("sb_pending", 32'(sb_q.size() != 0), 32'd1);
                    if (sb_q.size() != 0) begin
                        sb_head = sb_q.pop_front();
                        checkOutput($sformatf("sb_beat_ch%0d", n), {22'b0, 2'(n), out_data}, {22'b0, sb_head});
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        mode      = 1'b0;
        ch_en     = 4'b1111;
        out_ready = 4'b1111;
`ifdef DEMUX_ROUTE_STATS_EN
        stat_clr  = 1'b0;
`endif
        applyStimulus(1'b1, 8'h99, 2'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(1'b0, 8'h00, 2'd0);
        @(negedge clk);
        checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'h1);
        checkOutput("rst_cur_ch", 32'(cur_ch), 32'h0);
        checkOutput("rst_err_drop", 32'(err_drop), 32'h0);
        checkOutput("rst_out_data", 32'(out_data), 32'h0);
        tick();

        $display("[TB] addressed back-to-back");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 8'(8'hA0 + i), 2'(i));
            @(negedge clk);
            checkOutput("addr_in_ready", 32'(in_ready), 32'h1);
            if (i > 0) checkOutput("addr_out_valid", 32'(out_valid), 32'(4'b0001 << (i - 1)));
            sb_q.push_back({2'(i), 8'(8'hA0 + i)});
            tick();
        end
        applyStimulus(1'b0, 8'h00, 2'd0);
        @(negedge clk);
        checkOutput("addr_last_valid", 32'(out_valid), 32'h8);
        checkOutput("addr_last_data", 32'(out_data), 32'hA3);
        tick();
        @(negedge clk);
        checkOutput("addr_idle_valid", 32'(out_valid), 32'h0);
        tick();

        $display("[TB] addressed drop on disabled channel");
        ch_en = 4'b1011;
        beat(8'h55, 2'd2, 1'b1, 1'b0, 2'd0);
        applyStimulus(1'b0, 8'h00, 2'd0);
        @(negedge clk);
        checkOutput("drop_err_pulse", 32'(err_drop), 32'h1);
        checkOutput("drop_out_valid", 32'(out_valid), 32'h0);
        tick();
        @(negedge clk);
        checkOutput("drop_err_end", 32'(err_drop), 32'h0);
        tick();

        $display("[TB] round-robin bursts over mask 1101");
        mode  = 1'b1;
        ch_en = 4'b1101;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, 8'(8'hB0 + i), 2'd0);
            @(negedge clk);
            checkOutput("rr_in_ready", 32'(in_ready), 32'h1);
            if (i > 0) checkOutput("rr_cur_ch", 32'(cur_ch), ((i - 1) < 4) ? 32'd0 : ((i - 1) < 8) ? 32'd2 : 32'd3);
            sb_q.push_back({(i < 4) ? 2'd0 : (i < 8) ? 2'd2 : 2'd3, 8'(8'hB0 + i)});
            tick();
        end
        applyStimulus(1'b0, 8'h00, 2'd0);
        @(negedge clk);
        checkOutput("rr_last_valid", 32'(out_valid), 32'h8);
        tick();
        @(negedge clk);
        checkOutput("rr_ptr_wrap", 32'(cur_ch), 32'h0);
        tick();

        $display("[TB] back-pressure on ch1");
        mode      = 1'b0;
        ch_en     = 4'b1111;
        out_ready = 4'b1101;
        beat(8'h11, 2'd1, 1'b1, 1'b1, 2'd1);
        applyStimulus(1'b1, 8'h22, 2'd2);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("bp_in_ready", 32'(in_ready), 32'h0);
            checkOutput("bp_out_data", 32'(out_data), 32'h11);
            checkOutput("bp_out_valid", 32'(out_valid), 32'h2);
            tick();
        end
        out_ready = 4'b1111;
        @(negedge clk);
        checkOutput("bp_release_ready", 32'(in_ready), 32'h1);
        sb_q.push_back({2'd2, 8'h22});
        tick();
        applyStimulus(1'b0, 8'h00, 2'd0);
        @(negedge clk);
        checkOutput("bp_next_valid", 32'(out_valid), 32'h4);
        tick();

        $display("[TB] round-robin realign and stall");
        mode  = 1'b1;
        ch_en = 4'b1111;
        beat(8'h30, 2'd0, 1'b1, 1'b1, 2'd0);
        beat(8'h31, 2'd0, 1'b1, 1'b1, 2'd0);
        ch_en = 4'b1110;
        beat(8'h32, 2'd0, 1'b0, 1'b0, 2'd0);
        beat(8'h32, 2'd0, 1'b1, 1'b1, 2'd1);
        beat(8'h33, 2'd0, 1'b1, 1'b1, 2'd1);
        beat(8'h34, 2'd0, 1'b1, 1'b1, 2'd1);
        beat(8'h35, 2'd0, 1'b1, 1'b1, 2'd1);
        beat(8'h36, 2'd0, 1'b1, 1'b1, 2'd2);
        ch_en = 4'b0000;
        beat(8'h37, 2'd0, 1'b0, 1'b0, 2'd0);
        beat(8'h37, 2'd0, 1'b0, 1'b0, 2'd0);
        applyStimulus(1'b0, 8'h00, 2'd0);
        ch_en = 4'b1111;
        @(negedge clk);
        checkOutput("stall_drained", 32'(out_valid), 32'h0);
        tick();

        $display("[TB] reset while holding");
        mode      = 1'b0;
        out_ready = 4'b0000;
        beat(8'h77, 2'd3, 1'b1, 1'b0, 2'd0);
        applyStimulus(1'b0, 8'h00, 2'd0);
        @(negedge clk);
        checkOutput("midrst_held", 32'(out_valid), 32'h8);
        tick();
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        out_ready = 4'b1111;
        @(negedge clk);
        checkOutput("midrst_out_valid", 32'(out_valid), 32'h0);
        checkOutput("midrst_cur_ch", 32'(cur_ch), 32'h0);
        checkOutput("midrst_in_ready", 32'(in_ready), 32'h1);
        tick();

`ifdef DEMUX_ROUTE_STATS_EN
        $display("[TB] transfer statistics");
        for (int i = 0; i < 5; i++) beat(8'(8'hC0 + i), 2'd3, 1'b1, 1'b1, 2'd3);
        applyStimulus(1'b0, 8'h00, 2'd0);
        tick();
        @(negedge clk);
        checkOutput("stat_cnt3", 32'(stat_cnt3), 32'd5);
        checkOutput("stat_cnt0", 32'(stat_cnt0), 32'd0);
        tick();
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        @(negedge clk);
        checkOutput("stat_clr", 32'(stat_cnt3), 32'd0);
        tick();
`endif

        @(negedge clk);
        checkOutput("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
